// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_e       : controller states (IDLE, LOAD, CALC, SEND)
//   MODE_ADD/SUB  : encoding of mode_i (0 = A+B, 1 = A-B)
//   DEFAULT_WIDTH : default operand width
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        SEND = 2'd3
    } state_e;

    localparam logic MODE_ADD      = 1'b0;
    localparam logic MODE_SUB      = 1'b1;
    localparam int   DEFAULT_WIDTH = 2;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first parallel-in / serial-out shift register.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load data_i (has priority over shift_i)
//   data_i   : parallel word to serialise
//   shift_i  : shift right by one, zero filling from the top
//   sout_o   : current LSB
module serial_shift_reg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         shift_i,
    output logic         sout_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {1'b0, sr_q[W-1:1]};
        end
    end

    assign sout_o = sr_q[0];

endmodule

// File: rtl/param_serial_adder.sv
// Bit-serial adder/subtractor. Operands arrive LSB first over WIDTH
// consecutive en_i cycles; the WIDTH+1-bit result leaves LSB first over
// WIDTH+1 consecutive en_o cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   en_i      : operand bit valid
//   ina, inb  : operand A / B bit
//   mode_i    : 0 = A+B, 1 = A-B (sampled with bit 0 only)
//   en_o, out : result valid / result bit (out is 0 while en_o=0)
//   busy_o    : controller not in IDLE
//   err_o     : one-cycle pulse on aborted load or en_i while computing/sending
module param_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic ina,
    input  logic inb,
    input  logic mode_i,
    output logic en_o,
    output logic out,
    output logic busy_o,
    output logic err_o
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IN  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(WIDTH);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               mode_q;
    logic               en_q, out_q, busy_q, err_q;

    logic [WIDTH:0]     res_d;
    logic [WIDTH-1:0]   a_bit_d, b_bit_d;
    logic               sh_load, sh_shift, sh_bit;
    logic               send_done;

    // Operand bit placed at the counter position, OR-ed into the register.
    assign a_bit_d = WIDTH'(ina) << cnt_q;
    assign b_bit_d = WIDTH'(inb) << cnt_q;

    // Zero-extended arithmetic; subtraction wraps mod 2^(WIDTH+1) so an
    // underflow shows up as result[WIDTH]=1.
    always_comb begin
        res_d = {1'b0, a_q} + {1'b0, b_q};
        if (mode_q == MODE_SUB) begin
            res_d = {1'b0, a_q} - {1'b0, b_q};
        end
    end

    // en_q marks that bit 0 is already out, so the counter only advances
    // from the second SEND edge; bit WIDTH is out once it reads WIDTH.
    assign send_done = en_q && (cnt_q == LAST_OUT);
    assign sh_load   = (state_q == CALC);
    assign sh_shift  = (state_q == SEND) && !send_done;

    serial_shift_reg #(.W(WIDTH + 1)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .data_i  (res_d),
        .shift_i (sh_shift),
        .sout_o  (sh_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    en_q  <= 1'b0;
                    out_q <= 1'b0;
                    if (en_i) begin
                        a_q     <= {{(WIDTH-1){1'b0}}, ina};
                        b_q     <= {{(WIDTH-1){1'b0}}, inb};
                        mode_q  <= mode_i;
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (en_i) begin
                        a_q    <= a_q | a_bit_d;
                        b_q    <= b_q | b_bit_d;
                        busy_q <= 1'b1;
                        if (cnt_q == LAST_IN) begin
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        // Operand stream broke: drop the partial operands.
                        a_q     <= '0;
                        b_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (en_i) err_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (en_i) err_q <= 1'b1;
                    if (send_done) begin
                        en_q    <= 1'b0;
                        out_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        en_q  <= 1'b1;
                        out_q <= sh_bit;
                        if (en_q) cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_o   = en_q;
    assign out    = out_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: doc/param_serial_adder.md
PARAM_SERIAL_ADDER -- requirements
Module: param_serial_adder

Interface
REQ-001 The block SHALL have parameter: WIDTH, 2, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port: en_i  input  1  operand-valid; high for WIDTH consecutive cycles per operation.
REQ-005 The block SHALL have port: ina  input  1  serial operand A bit, LSB first.
REQ-006 The block SHALL have port: inb  input  1  serial operand B bit, LSB first.
REQ-007 The block SHALL have port: mode_i  input  1  0 = A+B, 1 = A-B; sampled with the first operand bit only.
REQ-008 The block SHALL have port: en_o  output  1  result-valid; high for exactly WIDTH+1 consecutive cycles per completed operation.
REQ-009 The block SHALL have port: out  output  1  serial result bit, LSB first; 0 whenever en_o=0.
REQ-010 The block SHALL have port: busy_o  output  1  high in any state other than IDLE.
REQ-011 The block SHALL have port: err_o  output  1  one-cycle protocol-error pulse.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, CALC, SEND; all outputs SHALL be registered.
REQ-013 IDLE: en_i=1 at an edge SHALL capture ina/inb into bit 0, latch mode_i, load bit counter to 1, go to LOAD; en_i=0 stays IDLE.
REQ-014 LOAD: each edge with en_i=1 SHALL capture the next bit at the counter index; the edge capturing bit WIDTH-1 SHALL go to CALC.
REQ-015 LOAD: en_i=0 at an edge SHALL abort: go to IDLE, clear operand registers, pulse err_o for one cycle, produce no en_o.
REQ-016 CALC: one edge SHALL register result = A+B (mode 0) or A-B mod 2^(WIDTH+1) (mode 1) as a WIDTH+1-bit value, zero-extended operands, and enter SEND with en_o=1, out=result[0].
REQ-017 Latency: en_o SHALL rise on the second edge after the edge sampling operand bit WIDTH-1.
REQ-018 SEND: out SHALL present result[i] in the i-th en_o cycle, i = 0..WIDTH; after bit WIDTH the next edge SHALL return to IDLE with en_o=0, out=0.
REQ-019 Any edge sampling en_i=1 while in CALC or SEND SHALL be ignored for data and SHALL pulse err_o for that cycle; the operation in flight SHALL complete unaffected.
REQ-020 A new operation SHALL be accepted at the first edge in IDLE (minimum gap one cycle between en_o falling and en_i acceptance).
REQ-021 Bit counter SHALL be $clog2(WIDTH+1) bits and SHALL never wrap outside 0..WIDTH.
REQ-022 Subtraction underflow SHALL appear as result[WIDTH]=1 (two's-complement sign); no separate flag.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, operand/result registers 0, en_o=0, out=0, busy_o=0, err_o=0, regardless of clock.
REQ-024 Reset asserted mid-LOAD or mid-SEND SHALL discard the operation; no partial output after release.
REQ-025 First edge after rst deasserts SHALL be able to accept en_i=1 as bit 0.

Structure
REQ-026 A shared package adder_pkg SHALL hold the state enum (IDLE, LOAD, CALC, SEND), the mode encoding constants, and the default WIDTH.
REQ-027 A single sub-module serial_shift_reg (parametrised width, LSB-first shift out, load enable) SHALL be used for the SEND serialiser; capture logic stays in the top.

Verification (WIDTH=4)
REQ-028 A=4'b1011 (11), B=4'b0110 (6), mode 0, en_i 4 cycles -> en_o 5 cycles, out LSB-first 1,0,0,0,1 (17), rising 2 edges after last bit.
REQ-029 A=3, B=5, mode 1 -> result 5'b11110, out 0,1,1,1,1; A=15, B=15 mode 0 -> 30, out 0,1,1,1,1.
REQ-030 en_i dropped after 2 bits -> err_o one-cycle pulse, busy_o falls, no en_o; next full operation correct.
REQ-031 en_i=1 during SEND for 2 cycles -> err_o high those 2 cycles, in-flight result bits unchanged.
REQ-032 rst pulsed asynchronously (between edges) during SEND bit 2 -> en_o, out, busy_o drop immediately; post-reset A=1, B=1 mode 0 -> out 0,1,0,0,0.
REQ-033 Back-to-back: new en_i asserted first cycle after en_o falls -> accepted, correct second result; random 1000-op run vs. reference model, zero mismatches.
